fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 23 ++
 rtl/flopenrc.sv | 36 +++
 rtl/fetch_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, reset defaults and helpers for the fetch stage
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] index);
    return {pc_hi, index, 2'b00};
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
    return (inc && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/response bus between fetch and imem
interface fetch_if;

  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - register with async active-low reset, enable and enabled synchronous clear
module flopenrc #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Clear only takes effect when enabled, so a held register ignores it.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? CLR_VAL : d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection and IF/ID pipeline register
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           stallF,
  input  logic           stallD,
  input  logic           pcsrcD,
  input  logic           jumpD,
  input  logic [31:0]    pcbranchD,
  fetch_if.master        imem,
  output logic [31:0]    instrD,
  output logic [31:0]    pcplus4D,
  output logic           validD,
  output logic           fetch_waitF,
  output logic [31:0]    perf_fetched,
  output logic [31:0]    perf_stall,
  output logic [31:0]    perf_flush
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [31:0] pcF;
  logic [31:0] pc_next;
  logic [31:0] pcplus4F;
  logic        run;
  logic        redirect;
  logic        pc_en;
  logic        bubble;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  assign run      = (state_q == RUN);
  assign redirect = (pcsrcD | jumpD) & ~stallD;
  assign pcplus4F = pcF + 32'd4;

  // A redirect wins over stallF and a pending memory response.
  always_comb begin
    pc_next = pcF;
    pc_en   = 1'b0;
    if (run) begin
      if (redirect) begin
        pc_en   = 1'b1;
        pc_next = jumpD ? jump_target(pcplus4D[31:28], instrD[25:0]) : pcbranchD;
      end else if (!stallF && imem.imem_ready) begin
        pc_en   = 1'b1;
        pc_next = pcplus4F;
      end
    end
  end

  assign bubble = redirect | ~run | ~imem.imem_ready | stallF;

  flopenrc #(.WIDTH(32), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset_n(reset_n), .en(pc_en), .clr(1'b0), .d(pc_next), .q(pcF)
  );

  flopenrc #(.WIDTH(32), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(bubble), .d(imem.imem_rdata), .q(instrD)
  );

  flopenrc #(.WIDTH(32), .RST_VAL(32'h0), .CLR_VAL(32'h0)) u_pcplus4 (
    .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(1'b0), .d(pcplus4F), .q(pcplus4D)
  );

  flopenrc #(.WIDTH(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_valid (
    .clk(clk), .reset_n(reset_n), .en(~stallD), .clr(bubble), .d(1'b1), .q(validD)
  );

  assign imem.imem_req  = run;
  assign imem.imem_addr = pcF;
  assign fetch_waitF    = run & ~imem.imem_ready;

`ifdef FETCH_PERF_EN
  logic        load_valid;
  logic        stall_evt;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_fetched_d;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_flush_d;

  assign load_valid = ~stallD & ~bubble;
  assign stall_evt  = run & (stallF | ~imem.imem_ready) & ~redirect;

  always_comb begin
    perf_fetched_d = sat_inc(perf_fetched_q, load_valid);
    perf_stall_d   = sat_inc(perf_stall_q, stall_evt);
    perf_flush_d   = sat_inc(perf_flush_q, redirect);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
      perf_flush_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_stall   = 32'h0;
  assign perf_flush   = 32'h0;
`endif

endmodule
